// File: rtl/les_sched_pkg.sv
// ---------------------------------------------------------------------------
// les_sched_pkg
// Shared definitions for the LES core sequencer:
//   - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//   - seed and Galois tap mask of the auto-request LFSR (x^32+x^22+x^2+x+1)
//   - nominal les_top latency, counted in cycles from its start pulse to
//     the cycle in which busy is seen low
//   - lfsrNext(), one step of the right-shifting Galois LFSR
// ---------------------------------------------------------------------------
package les_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam logic [31:0] LFSR_SEED    = 32'hACE1ACE1;

    // Taps 32,22,2,1 map onto bits 31,21,1,0 of a right-shifting Galois LFSR.
    localparam logic [31:0] LFSR_TAPS    = 32'h80200003;

    localparam int          CORE_LATENCY = 4;

    // One LFSR step: shift right and fold the taps in when a one falls out.
    function automatic logic [31:0] lfsrNext(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/les_lfsr32.sv
// ---------------------------------------------------------------------------
// les_lfsr32
// 32-bit Galois LFSR that supplies plaintexts for the internal auto
// requester of les_sched. The module only exists when LES_SCHED_AUTO_EN is
// defined; the default build has no LFSR at all.
//
// Ports:
//   clk      in   system clock
//   clr      in   asynchronous active-high clear, reloads LFSR_SEED
//   step_i   in   advance the register by one step this cycle
//   value_o  out  current LFSR value
// ---------------------------------------------------------------------------
`ifdef LES_SCHED_AUTO_EN
module les_lfsr32
    import les_sched_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        step_i,
    output logic [31:0] value_o
);

    logic [31:0] lfsr_q;

    // Hold the value between grants; advance exactly once per auto grant.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lfsr_q <= LFSR_SEED;
        end else if (step_i) begin
            lfsr_q <= lfsrNext(lfsr_q);
        end
    end

    assign value_o = lfsr_q;

endmodule
`endif

// File: rtl/les_sched.sv
// ---------------------------------------------------------------------------
// les_sched
// Round-robin sequencer in front of the single LES encryption core
// (les_top). One request is accepted at a time. The core is started,
// monitored until busy falls (or a timeout expires), and the ciphertext is
// returned to the consumer together with the requester id.
//
// Parameters:
//   NUM_REQ      number of external requesters (1..4)
//   TIMEOUT_CYC  WAIT cycles allowed with core_busy high before abort (>=4)
//   RID_W        response id width, >= clog2(NUM_REQ+1)
//
// Ports:
//   clk             in   system clock
//   clr             in   asynchronous active-high reset
//   auto_en         in   enable internal LFSR requester (LES_SCHED_AUTO_EN only)
//   req_valid       in   per-requester request valid
//   req_data        in   plaintexts, requester i at [32*i+31:32*i]
//   req_ready       out  one-hot accept strobe, only ever set in IDLE
//   resp_valid      out  response valid
//   resp_ready      in   response consumer ready
//   resp_data       out  ciphertext, 0 on timeout
//   resp_id         out  index of the granted requester
//   resp_err        out  response produced by timeout
//   core_plaintext  out  plaintext to les_top
//   core_start      out  one-cycle start pulse to les_top
//   core_busy       in   busy from les_top
//   core_cipher     in   ciphertext from les_top
//   core_clr        out  clear to les_top: clr OR one-cycle abort pulse
//   trig            out  scope trigger, high through ISSUE and WAIT
//
// Optional feature (macro LES_SCHED_AUTO_EN): adds port auto_en and an
// LFSR requester with id NUM_REQ, granted only when no external request is
// pending. Its plaintext is the current LFSR value and the LFSR steps on
// each such grant.
// ---------------------------------------------------------------------------
module les_sched
    import les_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 16,
    parameter int RID_W       = 2
) (
    input  logic                  clk,
    input  logic                  clr,
`ifdef LES_SCHED_AUTO_EN
    input  logic                  auto_en,
`endif
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [RID_W-1:0]      resp_id,
    output logic                  resp_err,
    output logic [31:0]           core_plaintext,
    output logic                  core_start,
    input  logic                  core_busy,
    input  logic [31:0]           core_cipher,
    output logic                  core_clr,
    output logic                  trig
);

    // A one-requester build still needs a 1-bit pointer.
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    sched_state_e     state_q;
    logic [PTR_W-1:0] rrPtr_q;
    logic [PTR_W-1:0] rrPtr_d;
    logic [CNT_W-1:0] waitCnt_q;
    logic [31:0]      plaintext_q;
    logic [RID_W-1:0] respId_q;
    logic [31:0]      respData_q;
    logic             respErr_q;
    logic             respValid_q;
    logic             coreStart_q;
    logic             trig_q;
    logic             abort_q;

    logic             extHit;
    logic [PTR_W-1:0] extIdx;
    logic [PTR_W-1:0] candIdx;
    logic [31:0]      extData;
    logic [NUM_REQ-1:0] reqReadyVec;
    int               cand;

    // Round-robin search: walk the requesters starting at rrPtr_q and
    // wrapping, take the first one that is valid, and mux its plaintext.
    always_comb begin
        extHit  = 1'b0;
        extIdx  = '0;
        extData = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rrPtr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = PTR_W'(cand);
            if (!extHit && req_valid[candIdx]) begin
                extHit = 1'b1;
                extIdx = candIdx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == extIdx) begin
                extData = req_data[32*i +: 32];
            end
        end
    end

    // The pointer moves to the slot just after the winner, modulo NUM_REQ.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (extIdx == PTR_W'(NUM_REQ - 1)) begin
            rrPtr_d = '0;
        end else begin
            rrPtr_d = extIdx + PTR_W'(1);
        end
    end

    // The accept strobe is combinational so the requester sees it in the
    // same cycle the plaintext is latched; it is forced low during reset so
    // every output reads 0 while clr is high.
    always_comb begin
        reqReadyVec = '0;
        if (state_q == ST_IDLE && extHit && !clr) begin
            reqReadyVec[extIdx] = 1'b1;
        end
    end

    assign req_ready = reqReadyVec;

`ifdef LES_SCHED_AUTO_EN
    logic        autoHit;
    logic        lfsrStep;
    logic [31:0] lfsrValue;

    // The auto requester has strict lowest priority behind any external one.
    assign autoHit  = auto_en && !extHit;
    assign lfsrStep = (state_q == ST_IDLE) && autoHit;

    les_lfsr32 u_lfsr (
        .clk     (clk),
        .clr     (clr),
        .step_i  (lfsrStep),
        .value_o (lfsrValue)
    );
`endif

    // Main sequencer. core_start, trig, resp_valid and the abort pulse are
    // registered alongside the state so they change cleanly on the edge that
    // enters the state they belong to. An auto grant leaves rrPtr_q alone,
    // since the LFSR requester is not part of the external rotation.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            rrPtr_q     <= '0;
            waitCnt_q   <= '0;
            plaintext_q <= '0;
            respId_q    <= '0;
            respData_q  <= '0;
            respErr_q   <= 1'b0;
            respValid_q <= 1'b0;
            coreStart_q <= 1'b0;
            trig_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            coreStart_q <= 1'b0;
            abort_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (extHit) begin
                        plaintext_q <= extData;
                        respId_q    <= RID_W'(extIdx);
                        rrPtr_q     <= rrPtr_d;
                        coreStart_q <= 1'b1;
                        trig_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
`ifdef LES_SCHED_AUTO_EN
                    else if (autoHit) begin
                        plaintext_q <= lfsrValue;
                        respId_q    <= RID_W'(NUM_REQ);
                        coreStart_q <= 1'b1;
                        trig_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
`endif
                end
                ST_ISSUE: begin
                    waitCnt_q <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    waitCnt_q <= waitCnt_q + CNT_W'(1);
                    if (!core_busy) begin
                        respData_q  <= core_cipher;
                        respErr_q   <= 1'b0;
                        respValid_q <= 1'b1;
                        trig_q      <= 1'b0;
                        state_q     <= ST_DONE;
                    end else if (waitCnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        abort_q     <= 1'b1;
                        respData_q  <= '0;
                        respErr_q   <= 1'b1;
                        respValid_q <= 1'b1;
                        trig_q      <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        respValid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid     = respValid_q;
    assign resp_data      = respData_q;
    assign resp_id        = respId_q;
    assign resp_err       = respErr_q;
    assign core_plaintext = plaintext_q;
    assign core_start     = coreStart_q;
    assign trig           = trig_q;

    // The core is held in clear by the system reset and, after a timeout,
    // for the single cycle that abort_q is high.
    assign core_clr       = clr | abort_q;

endmodule

// File: tb/tb_les_sched.sv
// ---------------------------------------------------------------------------
// tb_les_sched
// Bench for les_sched with a behavioural stand-in for les_top (fixed
// latency, optional hang), a queue-based expectation model and a monitor
// that scores every cycle against that model.
// ---------------------------------------------------------------------------
module tb_les_sched;
    import les_sched_pkg::*;

    localparam int NUM_REQ     = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int RID_W       = 2;
    localparam int NOM_LAT     = CORE_LATENCY + 2;
    localparam int TO_LAT      = TIMEOUT_CYC + 2;

    logic                  clk;
    logic                  clr;
    logic                  autoEn;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [RID_W-1:0]      resp_id;
    logic                  resp_err;
    logic [31:0]           core_plaintext;
    logic                  core_start;
    logic                  core_busy;
    logic [31:0]           core_cipher;
    logic                  core_clr;
    logic                  trig;

    les_sched #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RID_W       (RID_W)
    ) dut (
        .clk            (clk),
        .clr            (clr),
`ifdef LES_SCHED_AUTO_EN
        .auto_en        (autoEn),
`endif
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_id        (resp_id),
        .resp_err       (resp_err),
        .core_plaintext (core_plaintext),
        .core_start     (core_start),
        .core_busy      (core_busy),
        .core_cipher    (core_cipher),
        .core_clr       (core_clr),
        .trig           (trig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cipher: any bijection works, the bench only needs to know it.
    function automatic logic [31:0] cipherOf(input logic [31:0] p);
        return ({p[7:0], p[31:8]} ^ 32'h3C5A96E1) + 32'h01010101;
    endfunction

    // Core stand-in: busy for CORE_LATENCY-1 cycles after start, or forever
    // while hangMode is set, until core_clr clears it.
    logic        hangMode;
    int          coreCnt;
    logic [31:0] corePt;

    always @(posedge clk or posedge core_clr) begin
        if (core_clr) begin
            coreCnt <= 0;
            corePt  <= '0;
        end else if (core_start) begin
            coreCnt <= CORE_LATENCY - 1;
            corePt  <= core_plaintext;
        end else if (coreCnt > 0 && !hangMode) begin
            coreCnt <= coreCnt - 1;
        end
    end

    assign core_busy   = (coreCnt != 0);
    assign core_cipher = cipherOf(corePt);

    // Scoring.
    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual === required) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] pt;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t expQ[$];
    int   grantLog[$];
    int   grantCount[NUM_REQ];
    int   mRr       = 0;
    bit   modelIdle = 1'b1;
    int   grantCyc  = 0;
    bit   respSeen  = 1'b0;

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        logic [NUM_REQ-1:0] expReady;
        int   g;
        int   actG;
        int   lat;
        bit   inOp;
        logic expClr;
        exp_t e;
        for (int i = 0; i < NUM_REQ; i++) grantCount[i] = 0;
        forever begin
            @(negedge clk);
            if (clr) begin
                expQ.delete();
                mRr       = 0;
                modelIdle = 1'b1;
                respSeen  = 1'b0;
                continue;
            end

            // Request side: who should win, according to the rotation rule.
            expReady = '0;
            if (modelIdle && req_valid != '0) begin
                g = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && req_valid[(mRr + k) % NUM_REQ]) g = (mRr + k) % NUM_REQ;
                end
                expReady[g] = 1'b1;
                checkOutput("req_ready grant", 32'(req_ready), 32'(expReady));
                actG = -1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (actG < 0 && req_ready[i]) actG = i;
                end
                grantLog.push_back(actG);
                e.id   = g;
                e.pt   = req_data[32*g +: 32];
                e.err  = hangMode;
                e.data = hangMode ? 32'h0 : cipherOf(e.pt);
                e.lat  = hangMode ? TO_LAT : NOM_LAT;
                expQ.push_back(e);
                mRr       = (g + 1) % NUM_REQ;
                modelIdle = 1'b0;
                grantCyc  = cyc;
                grantCount[g]++;
            end else begin
                checkOutput("req_ready quiet", 32'(req_ready), 32'h0);
            end

            // Core-side pulses of the operation in flight.
            inOp = !modelIdle && expQ.size() > 0;
            lat  = inOp ? expQ[0].lat : 0;
            checkOutput("core_start", 32'(core_start), 32'(inOp && cyc == grantCyc + 1));
            checkOutput("trig", 32'(trig), 32'(inOp && cyc > grantCyc && cyc < grantCyc + lat));
            if (inOp && cyc == grantCyc + 1) begin
                checkOutput("core_plaintext issue", core_plaintext, expQ[0].pt);
            end

            // Response side.
            expClr = 1'b0;
            if (resp_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("resp_valid spurious", 32'(resp_valid), 32'h0);
                end else begin
                    if (!respSeen) begin
                        checkOutput("latency", 32'(cyc - grantCyc), 32'(expQ[0].lat));
                        respSeen = 1'b1;
                        expClr   = expQ[0].err;
                    end
                    checkOutput("resp_data", resp_data, expQ[0].data);
                    checkOutput("resp_id", 32'(resp_id), 32'(expQ[0].id));
                    checkOutput("resp_err", 32'(resp_err), 32'(expQ[0].err));
                    checkOutput("core_plaintext hold", core_plaintext, expQ[0].pt);
                    if (resp_ready) begin
                        void'(expQ.pop_front());
                        respSeen  = 1'b0;
                        modelIdle = 1'b1;
                    end
                end
            end else if (inOp && cyc >= grantCyc + lat) begin
                checkOutput("resp_valid missing", 32'(resp_valid), 32'h1);
            end
            checkOutput("core_clr", 32'(core_clr), 32'(expClr));
        end
    end

    // Stimulus helpers.
    int seenGrant[NUM_REQ];

    task automatic applyStimulus(input int cycles, input logic [NUM_REQ-1:0] holdMask,
                                 input int raisePct, input int dropPct, input int readyPct);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grantCount[i] != seenGrant[i]) begin
                    seenGrant[i] = grantCount[i];
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && (holdMask[i] ||
                    (raisePct > 0 && int'($urandom_range(99)) < raisePct))) begin
                    req_valid[i]           = 1'b1;
                    req_data[32*i +: 32]   = $urandom;
                end else if (req_valid[i] && dropPct > 0 && int'($urandom_range(99)) < dropPct) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = (int'($urandom_range(99)) < readyPct);
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while (!(expQ.size() == 0 && modelIdle && req_valid == '0) && n < maxCycles) begin
            applyStimulus(1, '0, 0, 0, 100);
            n++;
        end
        if (n >= maxCycles) begin
            checks++;
            $display("[TB] FAIL drain: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_ready"}, 32'(req_ready), 32'h0);
        checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
        checkOutput({tag, " resp_data"}, resp_data, 32'h0);
        checkOutput({tag, " resp_id"}, 32'(resp_id), 32'h0);
        checkOutput({tag, " resp_err"}, 32'(resp_err), 32'h0);
        checkOutput({tag, " core_plaintext"}, core_plaintext, 32'h0);
        checkOutput({tag, " core_start"}, 32'(core_start), 32'h0);
        checkOutput({tag, " trig"}, 32'(trig), 32'h0);
        checkOutput({tag, " core_clr"}, 32'(core_clr), 32'h1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        clr        = 1'b1;
        autoEn     = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        hangMode   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) seenGrant[i] = 0;

        // Reset state.
        #12;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Single request: requester 0, plaintext zero.
        @(posedge clk);
        #1;
        req_valid[0]  = 1'b1;
        req_data[31:0] = 32'h00000000;
        resp_ready    = 1'b1;
        waitDrain(100);

        // Timeout: the core never drops busy.
        hangMode = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1]    = 1'b1;
        req_data[63:32] = 32'hDEADBEEF;
        waitDrain(100);
        hangMode = 1'b0;

        // Contention: both requesters held for four grants.
        base = grantLog.size();
        n    = 0;
        while (grantLog.size() < base + 4 && n < 200) begin
            applyStimulus(1, 2'b11, 0, 0, 100);
            n++;
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            if (grantLog.size() > base + k) begin
                checkOutput("contention order", 32'(grantLog[base + k]), 32'(k % 2));
            end else begin
                checks++;
                $display("[TB] FAIL contention order: grant %0d missing, required %0d", k, k % 2);
            end
        end
        waitDrain(100);

        // Backpressure: response held for ten cycles with a request pending.
        @(posedge clk);
        #1;
        req_valid[0]   = 1'b1;
        req_data[31:0] = 32'h12345678;
        resp_ready     = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin
            applyStimulus(1, '0, 0, 0, 0);
            n++;
        end
        applyStimulus(10, 2'b10, 0, 0, 0);
        checkOutput("backpressure resp_valid", 32'(resp_valid), 32'h1);
        waitDrain(100);

        // Randomised traffic with drops and random consumer stalls.
        applyStimulus(300, '0, 25, 5, 70);
        waitDrain(300);

        // Reset in the middle of WAIT, after a grant to requester 0.
        @(posedge clk);
        #1;
        req_valid[0]   = 1'b1;
        req_data[31:0] = 32'hCAFEF00D;
        applyStimulus(3, '0, 0, 0, 100);
        #3;
        req_valid = 2'b11;
        req_data  = {32'h0BADF00D, 32'h600DCAFE};
        clr       = 1'b1;
        #1;
        checkResetOutputs("mid-wait reset");
        repeat (3) @(posedge clk);
        #1;
        base = grantLog.size();
        clr  = 1'b0;
        waitDrain(100);
        if (grantLog.size() > base) begin
            checkOutput("first grant after reset", 32'(grantLog[base]), 32'h0);
        end else begin
            checks++;
            $display("[TB] FAIL first grant after reset: no grant logged, required 0");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/les_sched.md
Name: les_sched

Overview:
- Sequencer/arbiter placed in front of the single LES encryption core (les_top).
- Accepts plaintext requests from NUM_REQ requesters via valid/ready and grants them round-robin.
- For each grant: drives the core start pulse, waits for busy to fall, captures the cipher, returns it with the requester id.
- Generates a scope trigger spanning the encryption; recovers a hung core via timeout and core clear.

Parameters:
- NUM_REQ, 2, number of external requesters (1..4).
- TIMEOUT_CYC, 16, WAIT cycles allowed with core_busy=1 before abort (>=4).
- RID_W, 2, response id width; must be >= clog2(NUM_REQ+1).

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  32*NUM_REQ  plaintexts; requester i occupies bits [32*i+31:32*i]
- req_ready  out  NUM_REQ  one-hot accept strobe
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_data  out  32  ciphertext (0 on error)
- resp_id  out  RID_W  index of the granted requester
- resp_err  out  1  response produced by timeout
- core_plaintext  out  32  to les_top plaintext_in
- core_start  out  1  to les_top start
- core_busy  in  1  from les_top busy
- core_cipher  in  32  from les_top cipher_out
- core_clr  out  1  to les_top clr; equals clr OR abort pulse
- trig  out  1  scope trigger

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, wait_cnt=0. All outputs 0 except core_clr, which is 1 while clr=1.
- States are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Grant the first valid requester searching from rr_ptr upward, modulo NUM_REQ.
  - Combinationally assert req_ready[g] that cycle.
  - Latch plaintext and id; set rr_ptr=(g+1) mod NUM_REQ; go to ISSUE.
  - No valid requester: stay in IDLE with rr_ptr unchanged.
- ISSUE (1 cycle): core_start=1, trig=1; go to WAIT with wait_cnt=0.
- WAIT:
  - trig=1, wait_cnt increments every cycle.
  - core_busy=0: register core_cipher into resp_data, resp_err=0, go to DONE.
  - Else if wait_cnt==TIMEOUT_CYC-1: pulse core_clr for 1 cycle, resp_data=0, resp_err=1, go to DONE.
- DONE: resp_valid=1 and resp_data/resp_id/resp_err held stable. When resp_valid && resp_ready, go to IDLE.
- Nominal latency with les_top:
  - Handshake cycle T.
  - ISSUE at T+1; busy observed high T+2..T+4 and low at T+5.
  - resp_valid rises at T+6.
- core_plaintext holds the latched value from ISSUE through DONE; it is 0 after reset.
- core_start is never asserted outside ISSUE, so the core cannot re-launch when its counter wraps to 0.
- At most one outstanding operation; req_ready=0 in every state except IDLE.
- Simultaneous requests: exactly one req_ready bit set per grant; all others wait.
- resp_ready asserted while not in DONE is ignored.
- A request deasserted before grant is dropped silently; no state change.
- Reset mid-operation: response lost, core cleared via core_clr, and the next grant restarts from rr_ptr=0.

Optional Feature:
- Macro: LES_SCHED_AUTO_EN.
- Defined:
  - Adds input auto_en (1 bit) and an internal LFSR requester with id NUM_REQ.
  - The LFSR requester is always valid while auto_en=1.
  - It is granted only when no external req_valid is set, so it has strict lowest priority.
  - On each grant the LFSR steps once and its current value is used as plaintext; responses carry resp_id=NUM_REQ.
  - LFSR seed after reset is 32'hACE1ACE1.
- Undefined: no auto_en port, no LFSR logic; resp_id never equals NUM_REQ.

Decomposition:
- Shared include les_sched_defs.vh holds:
  - state encodings (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
  - LFSR seed and taps (32,22,2,1)
  - nominal core latency constant (4)
- Sub-module les_lfsr32: 32-bit Galois LFSR with step enable and async clear, used only under LES_SCHED_AUTO_EN.

Test Plan:
- Single request: requester 0 sends 32'h00000000 → req_ready[0] at T, core_start at T+1, resp_valid at T+6, resp_data equal to the golden LES model, resp_id=0, resp_err=0.
- Contention: req_valid=2'b11 held for 4 operations → grants in order 0,1,0,1; each response's resp_id matches its grant.
- Backpressure: resp_ready=0 for 10 cycles in DONE → resp_* stable, req_ready=0 throughout; when resp_ready=1, the next grant occurs 1 cycle later.
- Timeout: stub core holds core_busy=1 → abort after TIMEOUT_CYC=16 WAIT cycles; core_clr is a 1-cycle pulse, resp_err=1, resp_data=0.
- Reset mid-WAIT: assert clr asynchronously → all outputs 0 immediately, core_clr=1 during reset, rr_ptr=0; a new request after release completes normally.
- LES_SCHED_AUTO_EN: auto_en=1, no external requests → resp_id=NUM_REQ with successive plaintexts following the LFSR sequence from 32'hACE1ACE1; an external request preempts at the next IDLE.
